lattice_fetch: RTL



---
 rtl/lattice_fetch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lattice_fetch.sv
// Lattice cell fetcher: reads the nine Q3.13 distributions of every cell in
// raster order and presents each bundle to the collider over a valid/ready handshake.
module lattice_fetch #(
    parameter int GRID_W = 64,
    parameter int GRID_H = 32,
    parameter int ADDR_W = 15,
    localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rd_data,
    output logic [15:0]       f_null,
    output logic [15:0]       f_n,
    output logic [15:0]       f_ne,
    output logic [15:0]       f_e,
    output logic [15:0]       f_se,
    output logic [15:0]       f_s,
    output logic [15:0]       f_sw,
    output logic [15:0]       f_w,
    output logic [15:0]       f_nw,
    output logic [XW-1:0]     cell_x,
    output logic [YW-1:0]     cell_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

    state_t            state, state_nx;
    logic [3:0]        dir;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] cell_off;
    logic              rd_pend;
    logic [3:0]        pend_dir;
    logic [15:0]       slot [9];

    logic last_dir, last_cell;
    assign last_dir  = (dir == 4'd8);
    assign last_cell = (cell_x == X_LAST) && (cell_y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   if (last_dir) state_nx = DRAIN;
            DRAIN:   state_nx = PRESENT;
            PRESENT: if (out_ready) state_nx = last_cell ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cell_off tracks 9*cell_index so the next cell's address needs only an add.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir      <= '0;
            base     <= '0;
            cell_off <= '0;
            mem_addr <= '0;
            cell_x   <= '0;
            cell_y   <= '0;
            rd_pend  <= 1'b0;
            pend_dir <= '0;
            for (int i = 0; i < 9; i++) slot[i] <= '0;
        end else begin
            rd_pend  <= (state == FETCH);
            pend_dir <= dir;
            if (rd_pend) slot[pend_dir] <= mem_rd_data;
            case (state)
                IDLE: if (start) begin
                    base     <= base_addr;
                    cell_off <= '0;
                    mem_addr <= base_addr;
                    dir      <= '0;
                    cell_x   <= '0;
                    cell_y   <= '0;
                end
                FETCH: if (!last_dir) begin
                    dir      <= dir + 4'd1;
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                PRESENT: if (out_ready && !last_cell) begin
                    dir      <= '0;
                    cell_off <= cell_off + ADDR_W'(9);
                    mem_addr <= base + cell_off + ADDR_W'(9);
                    if (cell_x == X_LAST) begin
                        cell_x <= '0;
                        cell_y <= cell_y + YW'(1);
                    end else begin
                        cell_x <= cell_x + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en = (state == FETCH);
    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    assign f_null = slot[0];
    assign f_n    = slot[1];
    assign f_ne   = slot[2];
    assign f_e    = slot[3];
    assign f_se   = slot[4];
    assign f_s    = slot[5];
    assign f_sw   = slot[6];
    assign f_w    = slot[7];
    assign f_nw   = slot[8];

endmodule
